// File: rtl/qerv_trap_seq.sv
// qerv_trap_seq: bit-serial CSR/trap pass sequencer; QERV_TRAP_SEQ_IRQ_EN enables the interrupt path
module qerv_trap_seq #(
  parameter int W = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req,
  input  logic [2:0] i_req_type,
  input  logic       i_new_irq,
  output logic       o_ack,
  output logic       o_irq_taken,
  output logic       o_busy,
  output logic       o_init,
  output logic       o_en,
  output logic       o_cnt0to3,
  output logic       o_cnt3,
  output logic       o_cnt7,
  output logic       o_cnt_done,
  output logic       o_trap,
  output logic       o_mret,
  output logic       o_e_op,
  output logic       o_ebreak,
  output logic       o_mem_op,
  output logic       o_mem_cmd
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] INIT = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] TRAP = 2'd3;
  localparam logic [4:0] STEP = 5'(W);
  localparam logic [4:0] LAST = 5'(32 - W);
  logic [1:0] state, state_n;
  logic [4:0] cnt;
  logic [2:0] typ;
  logic       is_irq, ack7, irq_pend, idle, req_v, exc, csr, mret_req, done, cause;
  assign idle     = state == IDLE;
  assign req_v    = idle && i_req && !ack7;
  assign exc      = req_v && i_req_type >= 3'd1 && i_req_type <= 3'd5;
  assign csr      = req_v && i_req_type == 3'd0;
  assign mret_req = req_v && i_req_type == 3'd6;
  assign done     = !idle && cnt == LAST;
`ifdef QERV_TRAP_SEQ_IRQ_EN
  // Interrupt flag: latched outside trap passes, consumed when its trap pass ends
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) irq_pend <= 1'b0;
    else if (o_irq_taken) irq_pend <= 1'b0;
    else if (i_new_irq && state != TRAP) irq_pend <= 1'b1;
`else
  logic unused_new_irq;
  assign unused_new_irq = i_new_irq;
  assign irq_pend       = 1'b0;
`endif
  // Next state: arbitration while idle, pass chaining otherwise
  always_comb
    state_n = idle ? (exc || irq_pend ? TRAP : csr ? INIT : mret_req ? RUN : IDLE)
            : !done ? state : state == INIT ? RUN : IDLE;
  // State, bit counter, reserved-type ack and request latch
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      typ    <= 3'd0;
      is_irq <= 1'b0;
      ack7   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= idle ? 5'd0 : cnt + STEP;
      ack7  <= req_v && i_req_type == 3'd7 && !irq_pend;
      if (idle) begin
        typ    <= i_req_type;
        is_irq <= irq_pend && !exc;
      end
    end
  assign cause       = o_trap && !is_irq;
  assign o_busy      = !idle;
  assign o_init      = state == INIT;
  assign o_en        = state == RUN || state == TRAP;
  assign o_trap      = state == TRAP;
  assign o_mret      = state == RUN && typ == 3'd6;
  assign o_e_op      = cause && (typ == 3'd1 || typ == 3'd2);
  assign o_ebreak    = cause && typ == 3'd2;
  assign o_mem_op    = cause && (typ == 3'd3 || typ == 3'd4);
  assign o_mem_cmd   = cause && typ == 3'd4;
  assign o_cnt0to3   = o_busy && (W == 1 ? cnt < 5'd4 : cnt == 5'd0);
  assign o_cnt3      = o_busy && (W == 1 ? cnt == 5'd3 : cnt == 5'd0);
  assign o_cnt7      = o_busy && (W == 1 ? cnt == 5'd7 : cnt == 5'd4);
  assign o_cnt_done  = done;
  assign o_ack       = ack7 || (done && (state == RUN || cause));
  assign o_irq_taken = done && o_trap && is_irq;
endmodule

// File: tb/tb_qerv_trap_seq.sv
// tb_qerv_trap_seq: W=1 and W=4 sequencers against a job/position reference model
module tb_qerv_trap_seq;
`ifdef QERV_TRAP_SEQ_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req [2];
  logic [2:0] rtype [2];
  logic nirq [2];
  logic [1:0][14:0] d;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  // d bits: 14 ack, 13 irq_taken, 12 busy, 11 init, 10 en, 9 cnt0to3, 8 cnt3, 7 cnt7, 6 cnt_done,
  //         5 trap, 4 mret, 3 e_op, 2 ebreak, 1 mem_op, 0 mem_cmd
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic ack, taken, busy, init, en, c03, c3, c7, cd, trap, mret, eop, ebrk, mop, mcmd;
    qerv_trap_seq #(.W(g == 0 ? 1 : 4)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_req(req[g]), .i_req_type(rtype[g]), .i_new_irq(nirq[g]),
      .o_ack(ack), .o_irq_taken(taken), .o_busy(busy), .o_init(init), .o_en(en),
      .o_cnt0to3(c03), .o_cnt3(c3), .o_cnt7(c7), .o_cnt_done(cd), .o_trap(trap), .o_mret(mret),
      .o_e_op(eop), .o_ebreak(ebrk), .o_mem_op(mop), .o_mem_cmd(mcmd));
    assign d[g] = {ack, taken, busy, init, en, c03, c3, c7, cd, trap, mret, eop, ebrk, mop, mcmd};
  end
  // Reference model: current job (-1 none, 0..6 request type, 8 interrupt) and cycles into it
  int m_job [2] = '{-1, -1};
  int m_pos [2] = '{0, 0};
  bit m_pend [2] = '{1'b0, 1'b0};
  bit m_ack7 [2] = '{1'b0, 1'b0};
  function automatic int plen(int i, int k);
    return (k == 0 ? 2 : 1) * (i == 0 ? 32 : 8);
  endfunction
  function automatic bit trapk(int k);
    return (k >= 1 && k <= 5) || k == 8;
  endfunction
  function automatic bit reqv(int i);
    return req[i] && !m_ack7[i];
  endfunction
  function automatic bit last(int i);
    return m_job[i] >= 0 && m_pos[i] == plen(i, m_job[i]) - 1;
  endfunction
  function automatic int pick(int i);
    if (reqv(i) && rtype[i] >= 3'd1 && rtype[i] <= 3'd5) return int'(rtype[i]);
    if (m_pend[i]) return 8;
    if (reqv(i) && (rtype[i] == 3'd0 || rtype[i] == 3'd6)) return int'(rtype[i]);
    return -1;
  endfunction
  function automatic logic [14:0] exp_out(int i);
    int k, n, w, c;
    bit lst, ini;
    k = m_job[i];
    if (k < 0) return {m_ack7[i], 14'd0};
    n = i == 0 ? 32 : 8;
    w = i == 0 ? 1 : 4;
    c = (m_pos[i] % n) * w;
    lst = m_pos[i] == plen(i, k) - 1;
    ini = k == 0 && m_pos[i] < n;
    return {lst && k != 8, lst && k == 8, 1'b1, ini, !ini,
            w == 1 ? c < 4 : c == 0, w == 1 ? c == 3 : c == 0, w == 1 ? c == 7 : c == 4,
            c == 32 - w, trapk(k), k == 6, k == 1 || k == 2, k == 2, k == 3 || k == 4, k == 4};
  endfunction
  always @(posedge clk or posedge rst)
    for (int i = 0; i < 2; i++)
      if (rst) begin
        m_job[i]  <= -1;
        m_pos[i]  <= 0;
        m_pend[i] <= 1'b0;
        m_ack7[i] <= 1'b0;
      end else begin
        m_ack7[i] <= m_job[i] < 0 && reqv(i) && rtype[i] == 3'd7 && !m_pend[i];
        m_pend[i] <= IRQ_EN && !(m_job[i] == 8 && last(i)) &&
                     (m_pend[i] || (nirq[i] && !trapk(m_job[i])));
        m_job[i]  <= m_job[i] < 0 ? pick(i) : last(i) ? -1 : m_job[i];
        m_pos[i]  <= (m_job[i] < 0 || last(i)) ? 0 : m_pos[i] + 1;
      end
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0;
      rtype[i] = 3'd0;
      nirq[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0;
      rtype[i] = 3'd0;
      nirq[i] = 1'b0;
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (d !== '0) begin errors++; $display("FAIL reset_hold dut=%h required=0", d); end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (d !== '0) begin errors++; $display("FAIL reset_release dut=%h required=0", d); end
  endtask
  task automatic test_ecall;
    int ack_at = -1, c3_at = -1, c7_at = -1, n_eop = 0, n_ebrk = 0;
    do_reset();
    req[0] = 1'b1;
    rtype[0] = 3'd1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      checks++;
      if (d[0] !== exp_out(0)) begin errors++; $display("FAIL ecall c=%0d dut=%b model=%b", c, d[0], exp_out(0)); end
      if (d[0][8] && c3_at < 0) c3_at = c;
      if (d[0][7] && c7_at < 0) c7_at = c;
      if (d[0][5] && d[0][3]) n_eop++;
      if (d[0][2]) n_ebrk++;
      if (d[0][14]) begin
        if (ack_at < 0) ack_at = c;
        req[0] = 1'b0;
      end
    end
    checks++;
    if (ack_at != 32) begin errors++; $display("FAIL ecall_ack offset=%0d required=32", ack_at); end
    checks++;
    if (c3_at != 4) begin errors++; $display("FAIL ecall_cnt3 offset=%0d required=4", c3_at); end
    checks++;
    if (c7_at != 8) begin errors++; $display("FAIL ecall_cnt7 offset=%0d required=8", c7_at); end
    checks++;
    if (n_eop != 32 || n_ebrk != 0) begin errors++; $display("FAIL ecall_strobes e_op=%0d ebreak=%0d required=32/0", n_eop, n_ebrk); end
  endtask
  task automatic test_csr_w4;
    int ack_at = -1, n_init = 0, n_en = 0, n_c7 = 0, c7_first = -1;
    do_reset();
    req[1] = 1'b1;
    rtype[1] = 3'd0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      checks++;
      if (d[1] !== exp_out(1)) begin errors++; $display("FAIL csr_w4 c=%0d dut=%b model=%b", c, d[1], exp_out(1)); end
      if (d[1][11]) n_init++;
      if (d[1][10]) n_en++;
      if (d[1][7]) begin
        n_c7++;
        if (c7_first < 0) c7_first = c;
      end
      if (d[1][14]) begin
        if (ack_at < 0) ack_at = c;
        req[1] = 1'b0;
      end
    end
    checks++;
    if (ack_at != 16) begin errors++; $display("FAIL csr_w4_ack offset=%0d required=16", ack_at); end
    checks++;
    if (n_init != 8 || n_en != 8) begin errors++; $display("FAIL csr_w4_passes init=%0d en=%0d required=8/8", n_init, n_en); end
    checks++;
    if (n_c7 != 2 || c7_first != 2) begin errors++; $display("FAIL csr_w4_cnt7 count=%0d first=%0d required=2/2", n_c7, c7_first); end
  endtask
  task automatic test_irq_csr;
    int ack_at = -1, taken_at = -1;
    do_reset();
    nirq[0] = 1'b1;
    @(negedge clk);
    nirq[0] = 1'b0;
    req[0] = 1'b1;
    rtype[0] = 3'd0;
    for (int c = 1; c <= 110; c++) begin
      @(negedge clk);
      checks++;
      if (d[0] !== exp_out(0)) begin errors++; $display("FAIL irq_csr c=%0d dut=%b model=%b", c, d[0], exp_out(0)); end
      if (d[0][13] && taken_at < 0) taken_at = c;
      if (d[0][14]) begin
        if (ack_at < 0) ack_at = c;
        req[0] = 1'b0;
      end
    end
    checks++;
    if (taken_at != (IRQ_EN ? 32 : -1)) begin errors++; $display("FAIL irq_csr_taken offset=%0d required=%0d", taken_at, IRQ_EN ? 32 : -1); end
    checks++;
    if (ack_at != (IRQ_EN ? 97 : 64)) begin errors++; $display("FAIL irq_csr_ack offset=%0d required=%0d", ack_at, IRQ_EN ? 97 : 64); end
  endtask
  task automatic test_misalign_irq;
    int ack_at = -1, taken_at = -1, n_mem = 0;
    do_reset();
    nirq[0] = 1'b1;
    @(negedge clk);
    nirq[0] = 1'b0;
    req[0] = 1'b1;
    rtype[0] = 3'd4;
    for (int c = 1; c <= 75; c++) begin
      @(negedge clk);
      checks++;
      if (d[0] !== exp_out(0)) begin errors++; $display("FAIL misalign_irq c=%0d dut=%b model=%b", c, d[0], exp_out(0)); end
      if (d[0][1] && d[0][0]) n_mem++;
      if (d[0][13] && taken_at < 0) taken_at = c;
      if (d[0][14]) begin
        if (ack_at < 0) ack_at = c;
        req[0] = 1'b0;
      end
    end
    checks++;
    if (ack_at != 32 || n_mem != 32) begin errors++; $display("FAIL misalign_st ack=%0d mem_cycles=%0d required=32/32", ack_at, n_mem); end
    checks++;
    if (taken_at != (IRQ_EN ? 65 : -1)) begin errors++; $display("FAIL misalign_irq_taken offset=%0d required=%0d", taken_at, IRQ_EN ? 65 : -1); end
  endtask
  task automatic test_reset_mid;
    int ack_at = -1, early_ack = 0;
    do_reset();
    req[0] = 1'b1;
    rtype[0] = 3'd2;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      checks++;
      if (d[0] !== exp_out(0)) begin errors++; $display("FAIL reset_mid_pre c=%0d dut=%b model=%b", c, d[0], exp_out(0)); end
      if (d[0][14]) early_ack++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (d[0] !== 15'd0) begin errors++; $display("FAIL reset_mid_async dut=%b required=0", d[0]); end
    @(negedge clk);
    checks++;
    if (d[0] !== 15'd0) begin errors++; $display("FAIL reset_mid_hold dut=%b required=0", d[0]); end
    rst = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      checks++;
      if (d[0] !== exp_out(0)) begin errors++; $display("FAIL reset_mid_post c=%0d dut=%b model=%b", c, d[0], exp_out(0)); end
      if (d[0][14]) begin
        if (ack_at < 0) ack_at = c;
        req[0] = 1'b0;
      end
    end
    checks++;
    if (ack_at != 32 || early_ack != 0) begin errors++; $display("FAIL reset_mid_ack offset=%0d aborted_acks=%0d required=32/0", ack_at, early_ack); end
  endtask
  task automatic test_mret_irq;
    int ack_at = -1, n_trap = 0;
    do_reset();
    req[0] = 1'b1;
    rtype[0] = 3'd6;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      checks++;
      if (d[0] !== exp_out(0)) begin errors++; $display("FAIL mret_irq c=%0d dut=%b model=%b", c, d[0], exp_out(0)); end
      if (c <= 32 && d[0][5]) n_trap++;
      if (d[0][14]) begin
        if (ack_at < 0) ack_at = c;
        req[0] = 1'b0;
      end
      nirq[0] = c <= 32 ? c[0] : 1'b0;
    end
    checks++;
    if (ack_at != 32 || n_trap != 0) begin errors++; $display("FAIL mret_irq_ack offset=%0d trap_cycles=%0d required=32/0", ack_at, n_trap); end
  endtask
  task automatic test_back_to_back;
    int n_ack [2] = '{0, 0};
    do_reset();
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (d[i] !== exp_out(i)) begin errors++; $display("FAIL random inst=%0d c=%0d dut=%b model=%b", i, c, d[i], exp_out(i)); end
        if (d[i][14]) begin
          n_ack[i]++;
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          rtype[i] = 3'($urandom_range(0, 7));
        end
        nirq[i] = $urandom_range(0, 15) == 0;
      end
    end
    checks++;
    if (n_ack[0] < 20 || n_ack[1] < 50) begin errors++; $display("FAIL random_progress acks=%0d/%0d required>=20/50", n_ack[0], n_ack[1]); end
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0;
      rtype[i] = 3'd0;
      nirq[i] = 1'b0;
    end
    test_reset();
    test_ecall();
    test_csr_w4();
    test_irq_csr();
    test_misalign_irq();
    test_reset_mid();
    test_mret_irq();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
